fsm: RTL and testbench

FSM -- requirements
Module: fsm

---
 rtl/fsm_pkg.sv | 15 +
 rtl/fsm_next_state.sv | 57 +++++
 rtl/fsm.sv | 49 ++++
 tb/tb_fsm.sv | 128 ++++++++++++
 4 files changed

// File: rtl/fsm_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// The overlap option (macro FSM_OVERLAP_EN) lives in fsm_next_state.
package fsm_pkg;

    localparam int          DEFAULT_PAT_W   = 4;
    localparam int          MIN_PAT_W       = 2;
    localparam int          MAX_PAT_W       = 16;
    localparam logic [15:0] DEFAULT_PATTERN = 16'b0110;

    // Width of a state index able to hold S0..S(pat_w).
    function automatic int state_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/fsm_next_state.sv
// Combinational next-state logic of the pattern detector (failure-function fallback).
// Define FSM_OVERLAP_EN to let MATCH fall back through the failure function.
module fsm_next_state
    import fsm_pkg::*;
#(
    parameter int               PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN[PAT_W-1:0],
    parameter int               SW      = state_w(PAT_W)
) (
    input  logic [SW-1:0] state,
    input  logic          in,
    output logic [SW-1:0] next
);

    // Pattern bit i counted from the first bit received (bit 0 is PATTERN[PAT_W-1]).
    function automatic logic pat_bit(input int i);
        logic [PAT_W-1:0] shifted;
        shifted = PATTERN >> (PAT_W - 1 - i);
        return shifted[0];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    // For k < PAT_W a matching b naturally yields k+1; the result never exceeds PAT_W.
    function automatic int longest_prefix(input int k, input logic b);
        int   best;
        int   pos;
        logic ok;
        logic hist;
        best = 0;
        for (int j = 1; j <= PAT_W; j++) begin
            ok = (j <= k + 1);
            for (int i = 0; i < j; i++) begin
                pos  = k + 1 - j + i;
                hist = (pos == k) ? b : pat_bit(pos);
                if (hist != pat_bit(i)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    // NOTE: the default assignment before the loop keeps every path assigned, so no latch is inferred.
    always_comb begin
        next = '0;
        for (int k = 0; k <= PAT_W; k++) begin
            if (state == SW'(k)) begin
`ifdef FSM_OVERLAP_EN
                next = SW'(longest_prefix(k, in));
`else
                next = (k == PAT_W) ? SW'(longest_prefix(0, in))
                                    : SW'(longest_prefix(k, in));
`endif
            end
        end
    end

endmodule

// File: rtl/fsm.sv
// Moore serial pattern detector: state register plus registered MATCH decode.
// Overlapping detection is enabled by defining FSM_OVERLAP_EN (off by default).
module fsm
    import fsm_pkg::*;
#(
    parameter int               PAT_W   = DEFAULT_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN[PAT_W-1:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    localparam int            SW    = state_w(PAT_W);
    localparam logic [SW-1:0] MATCH = SW'(PAT_W);

    if (PAT_W < MIN_PAT_W || PAT_W > MAX_PAT_W) begin : g_bad_pat_w
        $error("fsm: PAT_W must lie in 2..16");
    end

    logic [SW-1:0] state;
    logic [SW-1:0] next;

    fsm_next_state #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN),
        .SW      (SW)
    ) u_next_state (
        .state (state),
        .in    (in),
        .next  (next)
    );

    // out is registered alongside state, so it always equals (state == MATCH).
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= '0;
            out   <= 1'b0;
        end else begin
            state <= next;
            out   <= (next == MATCH);
        end
    end

    state_in_range: assert property (@(posedge clk) disable iff (reset) state <= MATCH);

endmodule

// File: tb/tb_fsm.sv
// Scoreboard bench for fsm: stimulus pushes expected out values, a monitor pops and compares.
// Expectations follow FSM_OVERLAP_EN, compiled with the same macro set as the RTL.
module tb_fsm;

    typedef struct {
        string name;
        logic  exp;
    } exp_t;

    logic clk = 1'b0;
    logic reset_a = 1'b1, in_a = 1'b0, out_a;
    logic reset_b = 1'b1, in_b = 1'b0, out_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fsm dut_a (
        .clk   (clk),
        .reset (reset_a),
        .in    (in_a),
        .out   (out_a)
    );

    fsm #(.PAT_W(3), .PATTERN(3'b111)) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .in    (in_b),
        .out   (out_b)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: out=%b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents out one time unit after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                check(e.name, out_a, e.exp);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                check(e.name, out_b, e.exp);
            end
        end
    end

    task automatic step_a(input string name, input logic r, input logic b, input logic e);
        exp_t x;
        @(negedge clk);
        reset_a = r;
        in_a    = b;
        x.name  = name;
        x.exp   = e;
        q_a.push_back(x);
    endtask

    task automatic step_b(input string name, input logic r, input logic b, input logic e);
        exp_t x;
        @(negedge clk);
        reset_b = r;
        in_b    = b;
        x.name  = name;
        x.exp   = e;
        q_b.push_back(x);
    endtask

    // Stimulus string: 'R' = reset cycle, '0'/'1' = data bit; exp holds out after each edge.
    task automatic run_a(input string name, input string bits, input string exp);
        for (int i = 0; i < bits.len(); i++) begin
            step_a($sformatf("%s[%0d]", name, i), bits[i] == "R", bits[i] == "1", exp[i] == "1");
        end
    endtask

    task automatic run_b(input string name, input string bits, input string exp);
        for (int i = 0; i < bits.len(); i++) begin
            step_b($sformatf("%s[%0d]", name, i), bits[i] == "R", bits[i] == "1", exp[i] == "1");
        end
    endtask

    initial begin
        run_a("reset_then_0110", "R01100", "000010");
`ifdef FSM_OVERLAP_EN
        run_a("overlap_stream", "R01101100110", "000010010001");
`else
        run_a("overlap_stream", "R01101100110", "000010000001");
`endif
        run_a("reset_mid_pattern", "R011R0110", "000000001");
        run_a("reset_in_match", "R0110R110", "000010000");

        step_a("zeros_reset", 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step_a($sformatf("zeros[%0d]", i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step_a($sformatf("ones[%0d]", i), 1'b0, 1'b1, 1'b0);

        @(negedge clk);
        reset_a = 1'b1;
`ifdef FSM_OVERLAP_EN
        run_b("all_ones_w3", "R111110", "0001110");
`else
        run_b("all_ones_w3", "R111110", "0001000");
`endif

        for (int i = 0; i < 5; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
